// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for eight DMA masters sharing one bus.
// Holds a registered one-hot grant until the slave signals ready or a watchdog expires.
module rr_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dma,
  input  logic       ready,
  output logic [7:0] grant,
  output logic       req,
  output logic [2:0] owner,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Count value seen on the last BUSY cycle before the watchdog revokes the grant.
  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] grant_nxt;
  logic [2:0] owner_nxt;
  logic [2:0] last;
  logic [2:0] last_nxt;
  logic [7:0] count;
  logic [7:0] count_nxt;
  logic       timeout_nxt;
  logic [3:0] pick;

  // Returns {found, index}: first set bit of vec searching upward from base+1, wrapping.
  function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      idx = base + 3'(i);
      if (!res[3] && vec[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    pick = rr_pick(dma, last);
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    owner_nxt   = owner;
    last_nxt    = last;
    count_nxt   = count;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick[3]) begin
          state_nxt = BUSY;
          grant_nxt = 8'b0000_0001 << pick[2:0];
          owner_nxt = pick[2:0];
          count_nxt = 8'd0;
        end
      end
      BUSY: begin
        // ready takes priority over a watchdog expiry in the same cycle
        if (ready || (count == COUNT_LAST)) begin
          state_nxt   = IDLE;
          grant_nxt   = 8'h00;
          owner_nxt   = 3'd0;
          last_nxt    = owner;
          timeout_nxt = !ready;
        end else begin
          count_nxt = sat_inc(count);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 8'h00;
      owner   <= 3'd0;
      last    <= 3'd7;
      count   <= 8'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      count   <= count_nxt;
      timeout <= timeout_nxt;
    end
  end

  assign req = (state == BUSY);

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: default-TIMEOUT instance plus a TIMEOUT=4 instance.
module tb_rr_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] dma;
  logic       ready;
  logic [7:0] grant;
  logic       req;
  logic [2:0] owner;
  logic       timeout;

  logic [7:0] dma4;
  logic       ready4;
  logic [7:0] grant4;
  logic       req4;
  logic [2:0] owner4;
  logic       timeout4;

  int total;
  int bad;

  rr_bus_arbiter dut (
    .clk(clk), .rst(rst), .dma(dma), .ready(ready),
    .grant(grant), .req(req), .owner(owner), .timeout(timeout)
  );

  rr_bus_arbiter #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .dma(dma4), .ready(ready4),
    .grant(grant4), .req(req4), .owner(owner4), .timeout(timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; dma = 8'h00; ready = 1'b0; dma4 = 8'h00; ready4 = 1'b0;
    #1;
    total++; if (grant !== 8'h00) begin bad++; $display("FAIL reset_grant got=%h exp=00", grant); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", req); end
    total++; if (owner !== 3'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    step;
    rst = 1'b0;
    ready = 1'b1;
    step;
    step;
    total++; if (grant !== 8'h00 || req !== 1'b0) begin bad++; $display("FAIL idle_no_req got grant=%h req=%b exp 00/0", grant, req); end
    ready = 1'b0;
  endtask

  task automatic test_basic;
    dma = 8'h81;
    step;
    total++; if (grant !== 8'h01) begin bad++; $display("FAIL basic_grant0 got=%h exp=01", grant); end
    total++; if (owner !== 3'd0) begin bad++; $display("FAIL basic_owner0 got=%0d exp=0", owner); end
    total++; if (req !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", req); end
    ready = 1'b1;
    step;
    total++; if (grant !== 8'h00 || req !== 1'b0) begin bad++; $display("FAIL basic_gap got grant=%h req=%b exp 00/0", grant, req); end
    step;
    ready = 1'b0;
    total++; if (grant !== 8'h80) begin bad++; $display("FAIL basic_grant7 got=%h exp=80", grant); end
    total++; if (owner !== 3'd7) begin bad++; $display("FAIL basic_owner7 got=%0d exp=7", owner); end
    step;
    total++; if (grant !== 8'h80) begin bad++; $display("FAIL basic_hold7 got=%h exp=80", grant); end
    ready = 1'b1; dma = 8'h00;
    step;
    ready = 1'b0;
  endtask

  task automatic test_rr_sweep;
    logic [7:0] exp_g;
    dma = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      step;
      total++; if (grant !== exp_g) begin bad++; $display("FAIL sweep_grant k=%0d got=%h exp=%h", k, grant, exp_g); end
      total++; if (owner !== 3'(k % 8)) begin bad++; $display("FAIL sweep_owner k=%0d got=%0d exp=%0d", k, owner, k % 8); end
      ready = 1'b1;
      step;
      ready = 1'b0;
      total++; if (grant !== 8'h00) begin bad++; $display("FAIL sweep_gap k=%0d got=%h exp=00", k, grant); end
    end
    dma = 8'h00;
    step;
  endtask

  task automatic test_hold_busy;
    dma = 8'h08;
    step;
    total++; if (grant !== 8'h08 || owner !== 3'd3) begin bad++; $display("FAIL hold_grant3 got=%h/%0d exp=08/3", grant, owner); end
    dma = 8'h20;
    for (int k = 0; k < 3; k++) begin
      step;
      total++; if (grant !== 8'h08 || req !== 1'b1) begin bad++; $display("FAIL hold_busy k=%0d got=%h/%b exp=08/1", k, grant, req); end
    end
    ready = 1'b1;
    step;
    ready = 1'b0;
    total++; if (grant !== 8'h00) begin bad++; $display("FAIL hold_release got=%h exp=00", grant); end
    step;
    total++; if (grant !== 8'h20 || owner !== 3'd5) begin bad++; $display("FAIL hold_next got=%h/%0d exp=20/5", grant, owner); end
    ready = 1'b1; dma = 8'h00;
    step;
    ready = 1'b0;
  endtask

  task automatic test_async_reset;
    dma = 8'h10;
    step;
    total++; if (grant !== 8'h10 || owner !== 3'd4) begin bad++; $display("FAIL areset_pre got=%h/%0d exp=10/4", grant, owner); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (grant !== 8'h00 || req !== 1'b0) begin bad++; $display("FAIL areset_drop got=%h/%b exp=00/0", grant, req); end
    total++; if (owner !== 3'd0) begin bad++; $display("FAIL areset_owner got=%0d exp=0", owner); end
    #1;
    rst = 1'b0;
    dma = 8'h11;
    step;
    total++; if (grant !== 8'h01 || owner !== 3'd0) begin bad++; $display("FAIL areset_first got=%h/%0d exp=01/0", grant, owner); end
    ready = 1'b1; dma = 8'h00;
    step;
    ready = 1'b0;
  endtask

  task automatic test_timeout;
    dma4 = 8'h04;
    step;
    dma4 = 8'h0C;
    total++; if (grant4 !== 8'h04 || owner4 !== 3'd2) begin bad++; $display("FAIL to_grant got=%h/%0d exp=04/2", grant4, owner4); end
    for (int k = 1; k < 4; k++) begin
      step;
      total++; if (grant4 !== 8'h04 || timeout4 !== 1'b0) begin bad++; $display("FAIL to_hold k=%0d got=%h/%b exp=04/0", k, grant4, timeout4); end
    end
    step;
    total++; if (grant4 !== 8'h00 || req4 !== 1'b0) begin bad++; $display("FAIL to_revoke got=%h/%b exp=00/0", grant4, req4); end
    total++; if (timeout4 !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout4); end
    total++; if (owner4 !== 3'd0) begin bad++; $display("FAIL to_owner got=%0d exp=0", owner4); end
    step;
    total++; if (timeout4 !== 1'b0) begin bad++; $display("FAIL to_pulse_end got=%b exp=0", timeout4); end
    total++; if (grant4 !== 8'h08 || owner4 !== 3'd3) begin bad++; $display("FAIL to_next got=%h/%0d exp=08/3", grant4, owner4); end
    dma4 = 8'h00; ready4 = 1'b1;
    step;
    ready4 = 1'b0;
    total++; if (grant4 !== 8'h00 || timeout4 !== 1'b0) begin bad++; $display("FAIL to_ready_rel got=%h/%b exp=00/0", grant4, timeout4); end
  endtask

  task automatic test_ready_wins;
    dma4 = 8'h01;
    step;
    dma4 = 8'h00;
    total++; if (grant4 !== 8'h01) begin bad++; $display("FAIL rw_grant got=%h exp=01", grant4); end
    step;
    step;
    step;
    total++; if (grant4 !== 8'h01) begin bad++; $display("FAIL rw_cycle4 got=%h exp=01", grant4); end
    ready4 = 1'b1;
    step;
    ready4 = 1'b0;
    total++; if (grant4 !== 8'h00 || timeout4 !== 1'b0) begin bad++; $display("FAIL rw_release got=%h/%b exp=00/0", grant4, timeout4); end
    step;
    total++; if (timeout4 !== 1'b0 || grant4 !== 8'h00) begin bad++; $display("FAIL rw_after got=%h/%b exp=00/0", grant4, timeout4); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_basic;
    test_rr_sweep;
    test_hold_busy;
    test_async_reset;
    test_timeout;
    test_ready_wins;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Parameters
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the number of BUSY cycles without ready after which the grant is revoked (legal range 1..255).

Interface
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port dma  input  8  bus request per DMA master; bit i = master i.
REQ-005 The block SHALL have port ready  input  1  slave signals that the current transfer is complete.
REQ-006 The block SHALL have port grant  output  8  registered one-hot grant, or all zero.
REQ-007 The block SHALL have port req  output  1  bus-busy indication, equal to OR of grant.
REQ-008 The block SHALL have port owner  output  3  binary index of the granted master; 0 when no grant.
REQ-009 The block SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (grant=0) and BUSY (grant one-hot, held constant).
REQ-011 In IDLE with dma != 0, the block SHALL select the first asserted bit searching upward from (last+1) mod 8, wrapping past 7 to 0.
REQ-012 On that edge, the block SHALL register grant, owner and the 8-bit watchdog count (cleared to 0), and SHALL enter BUSY; latency from request to grant is 1 cycle.
REQ-013 In IDLE with dma == 0, the block SHALL remain in IDLE; grant, owner and last SHALL be unchanged.
REQ-014 In BUSY, the block SHALL ignore all dma changes, including deassertion by the owner; grant SHALL be held until ready or timeout.
REQ-015 In BUSY with ready=1, the next edge SHALL: clear grant, set owner=0, load last with the released index, and enter IDLE.
REQ-016 In BUSY with ready=0, the block SHALL increment the count by 1 per cycle, saturating at 255.
REQ-017 In BUSY with ready=0 and count == TIMEOUT-1, the next edge SHALL: clear grant, load last with the released index, enter IDLE, and assert timeout for exactly that one following cycle.
REQ-018 If ready=1 in the cycle where the timeout condition would fire, ready SHALL win: normal release, no timeout pulse.
REQ-019 ready SHALL be ignored in IDLE.
REQ-020 After every release, the block SHALL spend at least one cycle in IDLE, so back-to-back grants are separated by exactly one grant-free cycle.
REQ-021 req SHALL be 1 exactly when in BUSY.
REQ-022 grant SHALL never have more than one bit set.
REQ-023 A master requesting continuously SHALL be granted within 8 grant cycles (starvation-free).

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, grant=8'h00, req=0, owner=0, timeout=0, count=0, last=7; the first arbitration therefore favours master 0.
REQ-025 rst asserted mid-BUSY SHALL drop grant immediately, without waiting for a clock edge.
REQ-026 After rst deasserts, the first rising edge SHALL arbitrate normally.

Verification
REQ-027 Reset then dma=8'h81 -> after 1 edge: grant=8'h01, owner=0, req=1; ready pulse -> IDLE one cycle -> grant=8'h80, owner=7.
REQ-028 dma=8'hFF held, ready pulsed once per grant -> grant sequence 01,02,04,...,80,01 with one zero cycle between grants.
REQ-029 TIMEOUT=4, grant to master 2, ready held 0 -> grant=8'h04 for 4 cycles, then grant=0 with timeout=1 for 1 cycle; next grant goes to a master above 2.
REQ-030 TIMEOUT=4, ready=1 on the 4th BUSY cycle -> normal release, timeout stays 0.
REQ-031 Owner 3 drops dma mid-BUSY while dma[5] rises -> grant stays 8'h08 until ready; then grant=8'h20.
REQ-032 rst pulsed mid-BUSY between clock edges -> grant=0 and req=0 immediately; next arbitration starts from master 0.
